// File: rtl/spi_mpu_burst.sv
// SPI mode-3 master for MPU register reads and writes, with bursts of 1..2^LEN_W data bytes per frame.
// Define SPI_MPU_BURST_EN to honour len; without it every frame carries exactly one data byte.
module spi_mpu_burst #(
  parameter int CLK_DIV   = 3,
  parameter int HOLD_BITS = 4,
  parameter int LEN_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  output logic             wr_req,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             finish,
  output logic             cs_n,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  // state | meaning
  // IDLE  | cs_n high, sclk high, waiting for start
  // SETUP | cs_n low, sclk high for 2^HOLD_BITS cycles
  // SHIFT | command byte then data bytes, MSB first
  // HOLD  | cs_n low, sclk high for 2^HOLD_BITS cycles
  // DONE  | one cycle, cs_n high, finish pulse
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  localparam int PH_W = CLK_DIV + 1;
  localparam logic [PH_W-1:0]      PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0]      PH_RISE = PH_W'((2 ** CLK_DIV) - 1);
  localparam logic [HOLD_BITS-1:0] TMR_ONE = HOLD_BITS'(1);

  state_t               state, state_nx;
  logic [HOLD_BITS-1:0] tmr;
  logic [PH_W-1:0]      ph;
  logic [2:0]           bitcnt;
  logic [7:0]           sh;
  logic [6:0]           rx;
  logic                 rw_q, cmd;
  logic                 rise, bit_end, byte_end, last_byte, wr_more;

  // ph counts 2H-1..0 per bit: upper half drives sclk low, lower half high
  assign rise     = (state == SHIFT) && (ph == PH_RISE);
  assign bit_end  = (state == SHIFT) && (ph == '0);
  assign byte_end = bit_end && (bitcnt == 3'd7);

`ifdef SPI_MPU_BURST_EN
  localparam int LW = LEN_W + 1;
  localparam logic [LEN_W:0] LEFT_ONE = LW'(1);
  logic [LEN_W:0] left;

  // data bytes still to send after the current one
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      left <= '0;
    else if (state == IDLE && start)
      left <= {1'b0, len} + LEFT_ONE;
    else if (byte_end && !last_byte)
      left <= left - LEFT_ONE;
  end

  assign last_byte = (left == '0);
  assign wr_more   = ~rw_q && (left != LEFT_ONE);
`else
  logic unused_len;
  assign unused_len = ^len;
  assign last_byte  = ~cmd;
  assign wr_more    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    finish   = 1'b0;
    cs_n     = 1'b1;
    sclk     = 1'b1;
    mosi     = 1'b1;
    case (state)
      IDLE: if (start) state_nx = SETUP;
      SETUP: begin
        busy = 1'b1;
        cs_n = 1'b0;
        if (tmr == '0) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        cs_n = 1'b0;
        sclk = ~ph[CLK_DIV];
        mosi = sh[7];
        if (byte_end && last_byte) state_nx = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        cs_n = 1'b0;
        mosi = sh[7];
        if (tmr == '0) state_nx = DONE;
      end
      DONE: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr      <= '0;
      ph       <= '0;
      bitcnt   <= '0;
      sh       <= '0;
      rx       <= '0;
      rw_q     <= 1'b0;
      cmd      <= 1'b0;
      wr_req   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_req   <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rw_q   <= rw;
          sh     <= {rw, addr};
          cmd    <= 1'b1;
          tmr    <= '1;
          ph     <= '1;
          bitcnt <= '0;
        end
        // timer wraps to all-ones on expiry, so HOLD starts pre-loaded
        SETUP, HOLD: tmr <= tmr - TMR_ONE;
        SHIFT: begin
          ph <= ph - PH_ONE;
          if (rise) begin
            rx <= {rx[5:0], miso};
            if (bitcnt == 3'd7 && rw_q && !cmd) begin
              rd_data  <= {rx, miso};
              rd_valid <= 1'b1;
            end
          end
          if (bit_end) begin
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt != 3'd7)
              sh <= {sh[6:0], 1'b1};
            else if (!last_byte) begin
              sh     <= rw_q ? 8'hFF : wr_data;
              cmd    <= 1'b0;
              wr_req <= wr_more;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mpu_burst.sv
// Directed bench for spi_mpu_burst: table of frames on a LEN_W=4 and a LEN_W=2 instance, plus reset mid-frame.
module tb_spi_mpu_burst;
  localparam int CLK_DIV   = 2;
  localparam int HOLD_BITS = 3;
`ifdef SPI_MPU_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    logic            sel;
    logic            rw;
    logic [6:0]      addr;
    logic [3:0]      len;
    logic [7:0][7:0] dat;
    logic            inj;
    int              nb;
    int              busy;
    int              nwr;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start1, start2, rw, miso, sel;
  logic [6:0] addr;
  logic [3:0] len;
  logic [7:0] wr_data;
  logic wr_req1, rd_valid1, busy1, finish1, cs_n1, sclk1, mosi1;
  logic wr_req2, rd_valid2, busy2, finish2, cs_n2, sclk2, mosi2;
  logic [7:0] rd_data1, rd_data2;
  logic m_wr_req, m_rd_valid, m_busy, m_finish, m_cs_n, m_sclk, m_mosi;
  logic [7:0] m_rd_data;

  spi_mpu_burst #(.CLK_DIV(CLK_DIV), .HOLD_BITS(HOLD_BITS), .LEN_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rw(rw), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_req(wr_req1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .busy(busy1), .finish(finish1), .cs_n(cs_n1), .sclk(sclk1), .mosi(mosi1), .miso(miso));

  spi_mpu_burst #(.CLK_DIV(CLK_DIV), .HOLD_BITS(HOLD_BITS), .LEN_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .rw(rw), .addr(addr), .len(len[1:0]),
    .wr_data(wr_data), .wr_req(wr_req2), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .busy(busy2), .finish(finish2), .cs_n(cs_n2), .sclk(sclk2), .mosi(mosi2), .miso(miso));

  assign m_wr_req   = sel ? wr_req2   : wr_req1;
  assign m_rd_valid = sel ? rd_valid2 : rd_valid1;
  assign m_busy     = sel ? busy2     : busy1;
  assign m_finish   = sel ? finish2   : finish1;
  assign m_cs_n     = sel ? cs_n2     : cs_n1;
  assign m_sclk     = sel ? sclk2     : sclk1;
  assign m_mosi     = sel ? mosi2     : mosi1;
  assign m_rd_data  = sel ? rd_data2  : rd_data1;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string vname;
  vec_t vecs [6];

  int cyc, t0, fin_t, busy_cyc, fin_cnt, wr_cnt, nbits, fcnt, wr_idx, cs_err, mosi_err, nrd;
  logic seen, sclk_p, mosi_p, cs_p;
  logic [7:0] cur, noise;
  logic [7:0] mbytes [20];
  logic [7:0] rdb [20];
  int rdt [20];
  logic [7:0][7:0] dcur;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d (0x%0h) expected %0d (0x%0h)", vname, nm, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; t0 = 0; fin_t = 0; busy_cyc = 0; fin_cnt = 0; wr_cnt = 0; nbits = 0;
    fcnt = 0; wr_idx = 0; cs_err = 0; mosi_err = 0; nrd = 0;
    seen = 1'b0; cur = 8'h00; sclk_p = 1'b1; mosi_p = 1'b1; cs_p = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mbytes[i] = 8'h00; rdb[i] = 8'h00; rdt[i] = 0;
    end
  endtask

  // one negedge sample: pin checks, miso slave model, host write-byte responder
  task automatic sample();
    int fb, bi;
    cyc++;
    if (m_busy) begin
      busy_cyc++;
      if (!seen) begin seen = 1'b1; t0 = cyc; end
    end
    if (m_cs_n !== ~m_busy) cs_err++;
    if (m_finish) begin fin_cnt++; fin_t = cyc; end
    if (m_wr_req) begin
      wr_cnt++;
      wr_idx++;
      if (wr_idx < 8) wr_data = dcur[wr_idx];
    end
    if (m_rd_valid) begin
      if (nrd < 20) begin rdb[nrd] = m_rd_data; rdt[nrd] = cyc - t0; end
      nrd++;
    end
    if (!m_cs_n && !cs_p && (m_mosi !== mosi_p) && !(sclk_p && !m_sclk)) mosi_err++;
    if (sclk_p && !m_sclk && !m_cs_n) begin
      fb = fcnt / 8;
      bi = 7 - (fcnt % 8);
      if (fb == 0) miso = noise[bi];
      else if (fb <= 8) miso = dcur[fb-1][bi];
      fcnt++;
    end
    if (!sclk_p && m_sclk && !m_cs_n) begin
      cur = {cur[6:0], m_mosi};
      nbits++;
      if ((nbits % 8 == 0) && (nbits / 8 <= 20)) mbytes[nbits/8 - 1] = cur;
    end
    sclk_p = m_sclk; mosi_p = m_mosi; cs_p = m_cs_n;
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    bit done;
    logic [7:0] expb;
    vname = nm;
    sel = v.sel; rw = v.rw; addr = v.addr; len = v.len;
    dcur = v.dat; wr_data = v.dat[0]; miso = 1'b1;
    clear_mon();
    @(negedge clk);
    if (v.sel) start2 = 1'b1; else start1 = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      sample();
      start1 = 1'b0; start2 = 1'b0;
      if (v.inj && (cyc == 40 || m_finish)) begin
        if (v.sel) start2 = 1'b1; else start1 = 1'b1;
      end
      if (fin_cnt > 0 && cyc >= fin_t + 4) done = 1'b1;
    end
    start1 = 1'b0; start2 = 1'b0;
    chk("completed", int'(done), 1);
    chk("busy_cycles", busy_cyc, v.busy);
    chk("finish_count", fin_cnt, 1);
    chk("finish_offset", fin_t - t0, v.busy);
    chk("idle_after", int'(m_busy), 0);
    chk("wr_req_count", wr_cnt, v.nwr);
    chk("mosi_bits", nbits, 8 * (v.nb + 1));
    chk("cmd_byte", int'(mbytes[0]), int'({v.rw, v.addr}));
    for (int j = 0; j < v.nb; j++) begin
      expb = v.rw ? 8'hFF : v.dat[j];
      chk($sformatf("mosi_byte%0d", j), int'(mbytes[j+1]), int'(expb));
    end
    chk("rd_valid_count", nrd, v.rw ? v.nb : 0);
    if (v.rw) begin
      for (int j = 0; j < v.nb; j++) begin
        chk($sformatf("rd_data%0d", j), int'(rdb[j]), int'(v.dat[j]));
        chk($sformatf("rd_time%0d", j), rdt[j], 133 + 64 * j);
      end
    end
    chk("cs_vs_busy", cs_err, 0);
    chk("mosi_off_fall", mosi_err, 0);
  endtask

  initial begin
    int post;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; sel = 1'b0;
    rw = 1'b0; addr = '0; len = '0; wr_data = '0; miso = 1'b1;
    noise = 8'h5A; dcur = '0;

    vecs[0] = '{1'b0, 1'b0, 7'h37, 4'd0, 64'h55, 1'b0, 1, 144, 0};
    vecs[1] = '{1'b0, 1'b1, 7'h3B, 4'd5, 64'h0000_A5A4_A3A2_A1A0, 1'b0,
                BURST ? 6 : 1, BURST ? 464 : 144, 0};
    vecs[2] = '{1'b0, 1'b0, 7'h6B, 4'd2, 64'h0000_0000_0033_2211, 1'b0,
                BURST ? 3 : 1, BURST ? 272 : 144, BURST ? 2 : 0};
    vecs[3] = '{1'b1, 1'b0, 7'h1A, 4'd3, 64'h0000_0000_C4C3_C2C1, 1'b1,
                BURST ? 4 : 1, BURST ? 336 : 144, BURST ? 3 : 0};
    vecs[4] = '{1'b0, 1'b0, 7'h19, 4'd7, 64'h8877_6655_4433_2211, 1'b0,
                BURST ? 8 : 1, BURST ? 592 : 144, BURST ? 7 : 0};
    vecs[5] = '{1'b1, 1'b1, 7'h75, 4'd3, 64'h0000_0000_A55A_C33C, 1'b0,
                BURST ? 4 : 1, BURST ? 336 : 144, 0};

    vname = "reset";
    repeat (3) @(negedge clk);
    chk("busy", int'(m_busy), 0);
    chk("finish", int'(m_finish), 0);
    chk("cs_n", int'(m_cs_n), 1);
    chk("sclk", int'(m_sclk), 1);
    chk("mosi", int'(m_mosi), 1);
    chk("wr_req", int'(m_wr_req), 0);
    chk("rd_valid", int'(m_rd_valid), 0);
    chk("rd_data", int'(m_rd_data), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // reset in the low half of bit 12 of a write burst
    vname = "reset_mid";
    sel = 1'b0; rw = 1'b0; addr = 7'h37; len = 4'd2;
    dcur = 64'h0000_0000_0033_220F; wr_data = 8'h0F;
    clear_mon();
    @(negedge clk);
    start1 = 1'b1;
    for (int c = 0; c < 2000 && nbits < 11; c++) begin
      @(negedge clk);
      sample();
      start1 = 1'b0;
    end
    repeat (5) begin @(negedge clk); sample(); end
    chk("bits_before_reset", nbits, 11);
    #2 rst = 1'b1;
    #1;
    chk("busy", int'(busy1), 0);
    chk("cs_n", int'(cs_n1), 1);
    chk("sclk", int'(sclk1), 1);
    chk("mosi", int'(mosi1), 1);
    chk("finish", int'(finish1), 0);
    chk("wr_req", int'(wr_req1), 0);
    chk("rd_valid", int'(rd_valid1), 0);
    chk("rd_data", int'(rd_data1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    post = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy1 || wr_req1 || rd_valid1 || finish1) post++;
    end
    chk("quiet_after_reset", post, 0);
    run_frame(vecs[0], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
